// File: rtl/ser_frame_collector.sv
// ser_frame_collector: assembles MSB-first frames from a qualified serial
// stream into a one-entry valid/ready holding register. It flags truncated
// frames, flags dropped words as overruns, and counts delivered words.
module ser_frame_collector #(
  parameter int FRAME_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Clk_EN,
  input  logic                 SerOut,
  input  logic                 SerOutValid,
  input  logic                 data_ready,
  output logic [FRAME_LEN-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [7:0]           frame_cnt
);

  localparam int BCW = $clog2(FRAME_LEN);
  localparam logic [BCW-1:0] BC_LAST = BCW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] sh_q, sh_d;
  logic [BCW-1:0]       bc_q, bc_d;
  logic [FRAME_LEN-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [7:0]           cnt_q, cnt_d;

  // Decoded per-edge actions
  logic                 take_bit, first_bit, complete, flush, trunc;
  logic [FRAME_LEN-1:0] word;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: a valid bit opens a frame; a gap in valid closes it
  always_comb begin
    state_d = state_q;
    if (Clk_EN) begin
      case (state_q)
        IDLE:    if (SerOutValid)  state_d = SHIFT;
        SHIFT:   if (!SerOutValid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: decode what this edge does to the datapath
  always_comb begin
    take_bit  = Clk_EN && SerOutValid;
    first_bit = take_bit && (state_q == IDLE);
    complete  = take_bit && (state_q == SHIFT) && (bc_q == BC_LAST);
    flush     = Clk_EN && !SerOutValid && (state_q == SHIFT);
    trunc     = flush && (bc_q != '0);
  end

  assign word = {sh_q[FRAME_LEN-2:0], SerOut};

  // Datapath next state: shifter, bit count, hold register and status
  always_comb begin
    sh_d   = sh_q;
    bc_d   = bc_q;
    data_d = data_q;
    dv_d   = dv_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    cnt_d  = cnt_q;
    if (Clk_EN) begin
      // The error pulse lasts exactly one enabled cycle
      ferr_d = trunc;
      if (take_bit) begin
        sh_d = word;
        if (first_bit)     bc_d = BCW'(1);
        else if (complete) bc_d = '0;
        else               bc_d = bc_q + 1'b1;
      end else begin
        // A partial frame is discarded when valid drops
        bc_d = '0;
        if (flush) sh_d = '0;
      end
      if (complete) begin
        if (!dv_q || data_ready) begin
          data_d = word;
          dv_d   = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end else begin
          ovr_d  = 1'b1;
        end
      end else if (dv_q && data_ready) begin
        dv_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      bc_q   <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      bc_q   <= bc_d;
      data_q <= data_d;
      dv_q   <= dv_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ser_frame_collector.sv
// Directed bench for ser_frame_collector with FRAME_LEN=8.
module tb_ser_frame_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Clk_EN = 1'b1;
  logic       SerOut = 1'b0;
  logic       SerOutValid = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic [7:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  ser_frame_collector #(.FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .SerOut(SerOut),
    .SerOutValid(SerOutValid), .data_ready(data_ready),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, return 1 ns after the rising edge
  task automatic step(input logic en, input logic v, input logic b, input logic rdy);
    @(negedge clk);
    Clk_EN = en; SerOutValid = v; SerOut = b; data_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Send the top n bits of w, MSB first; data_ready is rdy_last on the last edge only
  task automatic send_bits(input logic [7:0] w, input int n, input logic rdy, input logic rdy_last);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b1, w[7-i], (i == n-1) ? rdy_last : rdy);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; Clk_EN = 1'b1; SerOutValid = 1'b0; SerOut = 1'b0; data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data_out); end
    checks++; if ({data_valid, frame_err, overrun} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {data_valid, frame_err, overrun}); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", frame_cnt); end
    apply_reset();
  endtask

  task automatic test_single_frame();
    apply_reset();
    send_bits(8'hB2, 7, 1'b1, 1'b1);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", data_valid); end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (data_out !== 8'hB2 || data_valid !== 1'b1) begin failures++; $display("FAIL single_word got=%h/%b exp=b2/1", data_out, data_valid); end
    checks++; if (frame_cnt !== 8'd1 || frame_err !== 1'b0) begin failures++; $display("FAIL single_cnt got=%0d/%b exp=1/0", frame_cnt, frame_err); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (data_valid !== 1'b0 || frame_err !== 1'b0 || data_out !== 8'hB2) begin failures++; $display("FAIL single_after got=%b/%b/%h exp=0/0/b2", data_valid, frame_err, data_out); end
  endtask

  task automatic test_overrun();
    apply_reset();
    send_bits(8'hA5, 8, 1'b0, 1'b0);
    checks++; if (data_out !== 8'hA5 || data_valid !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_first got=%h/%b/%b exp=a5/1/0", data_out, data_valid, overrun); end
    send_bits(8'h3C, 8, 1'b0, 1'b0);
    checks++; if (overrun !== 1'b1 || data_out !== 8'hA5 || frame_cnt !== 8'd1) begin failures++; $display("FAIL ovr_drop got=%b/%h/%0d exp=1/a5/1", overrun, data_out, frame_cnt); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (data_valid !== 1'b0 || data_out !== 8'hA5 || overrun !== 1'b1) begin failures++; $display("FAIL ovr_consume got=%b/%h/%b exp=0/a5/1", data_valid, data_out, overrun); end
  endtask

  task automatic test_truncated();
    apply_reset();
    send_bits(8'hFF, 5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b1 || data_valid !== 1'b0) begin failures++; $display("FAIL trunc_err got=%b/%b exp=1/0", frame_err, data_valid); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL trunc_fall got=%b exp=0", frame_err); end
    send_bits(8'hFF, 7, 1'b0, 1'b0);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL trunc_bcreset got=%b exp=0", data_valid); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (data_out !== 8'hFF || data_valid !== 1'b1 || frame_cnt !== 8'd1) begin failures++; $display("FAIL trunc_next got=%h/%b/%0d exp=ff/1/1", data_out, data_valid, frame_cnt); end
    // Pending error holds through disabled cycles and clears on the next enabled edge
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_hold got=%b exp=1", frame_err); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_release got=%b exp=0", frame_err); end
  endtask

  task automatic test_same_edge();
    apply_reset();
    send_bits(8'h11, 8, 1'b0, 1'b0);
    send_bits(8'h22, 8, 1'b0, 1'b1);
    checks++; if (data_out !== 8'h22 || data_valid !== 1'b1) begin failures++; $display("FAIL same_word got=%h/%b exp=22/1", data_out, data_valid); end
    checks++; if (overrun !== 1'b0 || frame_cnt !== 8'd2) begin failures++; $display("FAIL same_cnt got=%b/%0d exp=0/2", overrun, frame_cnt); end
  endtask

  task automatic test_enable();
    apply_reset();
    send_bits(8'h5A, 4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send_bits(8'hA0, 3, 1'b0, 1'b0);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL en_early got=%b exp=0", data_valid); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (data_out !== 8'h5A || frame_cnt !== 8'd1) begin failures++; $display("FAIL en_word got=%h/%0d exp=5a/1", data_out, frame_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_bits(8'hAA, 8, 1'b0, 1'b0);
    send_bits(8'hAA, 8, 1'b0, 1'b0);
    send_bits(8'hF0, 4, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00 || data_valid !== 1'b0 || overrun !== 1'b0 || frame_cnt !== 8'd0 || frame_err !== 1'b0)
      begin failures++; $display("FAIL mid_rst got=%h/%b/%b/%0d/%b exp=00/0/0/0/0", data_out, data_valid, overrun, frame_cnt, frame_err); end
    @(negedge clk);
    rst = 1'b1; SerOutValid = 1'b0;
    send_bits(8'hC3, 8, 1'b0, 1'b0);
    checks++; if (data_out !== 8'hC3 || data_valid !== 1'b1 || frame_cnt !== 8'd1) begin failures++; $display("FAIL mid_next got=%h/%b/%0d exp=c3/1/1", data_out, data_valid, frame_cnt); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int f = 0; f < 256; f++) send_bits(8'(f), 8, 1'b1, 1'b1);
    checks++; if (frame_cnt !== 8'd0 || data_out !== 8'hFF || overrun !== 1'b0) begin failures++; $display("FAIL wrap got=%0d/%h/%b exp=0/ff/0", frame_cnt, data_out, overrun); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_truncated();
    test_same_edge();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_frame_collector.md
# ser_frame_collector

Downstream consumer of the serial pattern detector. It samples the detector's `SerOut` bit stream while `SerOutValid` is high and assembles fixed-length frames, first bit in the MSB. Each completed word goes into a one-entry holding register with a valid/ready handshake toward the parallel consumer. The block also flags truncated frames and overruns and counts delivered words.

## Interface
Parameters:
- `FRAME_LEN`, default 8: bits per frame, legal range 2..16. Sets the width of `data_out`.

Ports:
- `clk`  in  1: single clock; all sequential elements are on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (one clock; reset asynchronous, active-low).
- `Clk_EN`  in  1: global enable. When 0, every register holds its value.
- `SerOut`  in  1: serial data bit from the detector.
- `SerOutValid`  in  1: qualifies `SerOut`. The frame is active while it is high.
- `data_ready`  in  1: consumer accepts the held word.
- `data_out`  out  FRAME_LEN: held word; the first received bit is at bit FRAME_LEN-1.
- `data_valid`  out  1: `data_out` holds an unconsumed word.
- `frame_err`  out  1: one enabled-cycle pulse when a frame is truncated.
- `overrun`  out  1: sticky; a completed word was dropped. Cleared only by reset.
- `frame_cnt`  out  8: number of delivered words, modulo 256.

## Operation
- "Edge" below means a rising `clk` edge with `Clk_EN`=1. Non-enabled edges change nothing.
- Internal state:
  - shift register `sh[FRAME_LEN-1:0]`
  - bit counter `bc`, 0..FRAME_LEN-1
  - FSM with states IDLE and SHIFT
- IDLE:
  - If `SerOutValid`=1, sample `SerOut` into `sh[0]` (shift left), set `bc`=1, go to SHIFT.
  - Otherwise stay in IDLE with `bc`=0.
- SHIFT with `SerOutValid`=1:
  - Shift in `SerOut`.
  - If `bc`=FRAME_LEN-1 this edge completes the frame: the word is {sh[FRAME_LEN-2:0], SerOut}, `bc` becomes 0, and the state stays SHIFT. Back-to-back frames are therefore supported with no gap bit.
  - Otherwise `bc`=`bc`+1.
- SHIFT with `SerOutValid`=0:
  - If `bc`≠0, the frame is truncated: `frame_err` is 1 for the next enabled cycle, `sh` and `bc` clear, and the partial bits are discarded.
  - If `bc`=0 (ended exactly on a frame boundary), there is no error.
  - In both cases go to IDLE.
- Holding register behaviour on a completing edge:
  - Hold empty, or hold full with `data_ready`=1 on the same edge: load the word, set `data_valid`=1, `frame_cnt`+=1.
  - Hold full with `data_ready`=0: drop the word, set `overrun`=1, leave the hold and `frame_cnt` unchanged.
- Consume: on an edge with `data_valid`=1, `data_ready`=1 and no simultaneous completion, clear `data_valid`. `data_out` keeps its last value.
- `data_ready` while `data_valid`=0 is ignored.
- `frame_cnt` wraps from 255 to 0.

## Timing
- Reset (`rst`=0) takes effect immediately, with no clock needed:
  - `data_out`=0, `data_valid`=0, `frame_err`=0, `overrun`=0, `frame_cnt`=0
  - FSM in IDLE, `sh`=0, `bc`=0
- Reset in the middle of a frame discards the partial frame and any held word.
- The first edge after `rst` rises may sample a bit.
- Latency: `data_valid` and `data_out` update at the same edge that samples the final bit, i.e. 0 cycles after that edge. A frame started on edge n completes on edge n+FRAME_LEN-1.
- `frame_err` is registered: it rises at the edge where `SerOutValid`=0 is seen in SHIFT and falls at the next edge.
- `frame_err` and a completion cannot occur on the same edge.
- All outputs are registered; there are no combinational paths from input to output.
- With `Clk_EN`=0, a pending `frame_err` stays asserted until the next edge.

## Test plan
1. **Single frame.** Reset, then FRAME_LEN=8 and `data_ready`=1. Send bits 1,0,1,1,0,0,1,0 on 8 consecutive edges with `SerOutValid`=1, then drop `SerOutValid`. Expected: `data_out`=8'hB2, `data_valid` high for exactly 1 cycle, `frame_cnt`=1, `frame_err`=0.
2. **Overrun.** `data_ready`=0. Send 16 continuous valid bits 0xA5 then 0x3C. Expected: `data_out`=0xA5 and held, `overrun`=1 after the 16th edge, `frame_cnt`=1. Then raise `data_ready`. Expected: `data_valid`=0, `data_out` still 0xA5.
3. **Truncated frame.** Send 5 valid bits, then `SerOutValid`=0. Expected: `frame_err`=1 for one cycle, `data_valid` stays 0. Then a full frame 0xFF. Expected: `data_out`=0xFF, which shows the counter was reset.
4. **Completion and consume on the same edge.** 0x11 is pending. Assert `data_ready` on the edge that completes 0x22. Expected: `data_out`=0x22, `data_valid` stays 1, `overrun`=0, `frame_cnt`=2.
5. **Enable gating.** During frame 0x5A, drop `Clk_EN` for 3 cycles while toggling `SerOut`. Expected: those bits are ignored and `data_out`=0x5A.
6. **Reset mid-frame.** After 4 bits of a frame, pulse `rst` low asynchronously, between clock edges. Expected: all outputs are 0 immediately. Then a full frame 0xC3. Expected: `data_out`=0xC3, `frame_cnt`=1.
